// File: rtl/calc_alu_seq.sv
// Sequential add/sub/shift-add multiply/restoring divide core feeding the
// two-digit 7-segment driver; result is 2*WIDTH bits with a level valid flag.
module calc_alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic [2*WIDTH-1:0] result,
  output logic               result_valid,
  output logic               err
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CALC} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01,
                            OP_MUL = 2'b10, OP_DIV = 2'b11} op_t;

  state_t         state;
  logic [1:0]     op_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] mplier;
  logic [RW-1:0]  mcand;
  logic [RW-1:0]  acc;
  logic [CW-1:0]  cnt;
  logic           last;

  // Multiply: acc accumulates the product, mcand walks left, mplier walks right.
  logic [RW-1:0]  mul_sum;
  // Divide: acc holds {remainder, dividend->quotient}, shifted left each step.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] lo_sh;
  logic [WIDTH-1:0] rem_new;

  always_comb begin
    mul_sum = acc + (mplier[0] ? mcand : '0);
    rem_sh  = {acc[RW-1:WIDTH], acc[WIDTH-1]};
    diff    = rem_sh - {1'b0, b_r};
    lo_sh   = {acc[WIDTH-1:0], ~diff[WIDTH]};
    rem_new = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    last    = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      op_r         <= '0;
      b_r          <= '0;
      mplier       <= '0;
      mcand        <= '0;
      acc          <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (go) begin
          op_r         <= op;
          b_r          <= b;
          mplier       <= b;
          mcand        <= RW'(a);
          acc          <= (op == OP_DIV) ? RW'(a) : '0;
          cnt          <= '0;
          busy         <= 1'b1;
          result_valid <= 1'b0;
          err          <= 1'b0;
          state        <= CALC;
        end
        CALC: begin
          case (op_t'(op_r))
            OP_ADD: begin
              result       <= mcand + RW'(b_r);
              result_valid <= 1'b1;
              busy         <= 1'b0;
              state        <= IDLE;
            end
            OP_SUB: begin
              result       <= mcand - RW'(b_r);
              result_valid <= 1'b1;
              busy         <= 1'b0;
              state        <= IDLE;
            end
            OP_MUL: begin
              acc    <= mul_sum;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
              cnt    <= cnt + 1'b1;
              if (last) begin
                result       <= mul_sum;
                result_valid <= 1'b1;
                busy         <= 1'b0;
                state        <= IDLE;
              end
            end
            OP_DIV: begin
              if (b_r == '0) begin
                result       <= '1;
                err          <= 1'b1;
                result_valid <= 1'b1;
                busy         <= 1'b0;
                state        <= IDLE;
              end else begin
                acc <= {rem_new, lo_sh[WIDTH-1:0]};
                cnt <= cnt + 1'b1;
                if (last) begin
                  result       <= {lo_sh[WIDTH-1:0], rem_new};
                  result_valid <= 1'b1;
                  busy         <= 1'b0;
                  state        <= IDLE;
                end
              end
            end
            default: state <= IDLE;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_alu_seq.sv
// Randomized + directed bench for calc_alu_seq against an arithmetic reference model.
module tb_calc_alu_seq;
  localparam int W = 4;

  logic           clk = 0;
  logic           rst = 0;
  logic           go = 0;
  logic [1:0]     op = 0;
  logic [W-1:0]   a = 0, b = 0;
  logic           busy, result_valid, err;
  logic [2*W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W-1:0] last_res = '0;

  calc_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .go(go), .op(op), .a(a), .b(b),
    .busy(busy), .result(result), .result_valid(result_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on the operands.
  function automatic void model(input logic [1:0] o, input int x, input int y,
                                output logic [2*W-1:0] r, output logic e, output int lat);
    e = 0;
    lat = 2;
    case (o)
      2'b00: r = (2*W)'(x + y);
      2'b01: r = (2*W)'(x - y);
      2'b10: begin r = (2*W)'(x * y); lat = 1 + W; end
      default: begin
        if (y == 0) begin r = '1; e = 1; end
        else begin r = {W'(x / y), W'(x % y)}; lat = 1 + W; end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit inject, input int hold);
    logic [2*W-1:0] er;
    logic ee;
    int lat, n;
    model(o, int'(x), int'(y), er, ee, lat);
    go = 1; op = o; a = x; b = y;
    step();
    chk("accept_busy", busy, 1);
    chk("accept_rv_clr", result_valid, 0);
    chk("accept_err_clr", err, 0);
    chk("accept_res_kept", result, last_res);
    go = 0;
    a = W'($urandom); b = W'($urandom); op = 2'($urandom);
    n = 1;
    do begin
      if (inject) begin
        go = 1'($urandom); a = W'($urandom); b = W'($urandom); op = 2'($urandom);
      end
      step();
      n++;
      if (!result_valid) chk("calc_busy", busy, 1);
    end while (!result_valid && n < 20);
    go = 0;
    chk("latency", n, lat);
    chk("result", result, er);
    chk("err", err, ee);
    chk("done_busy", busy, 0);
    last_res = er;
    for (int i = 0; i < hold; i++) step();
    if (hold > 0) begin
      chk("hold_res", result, er);
      chk("hold_rv", result_valid, 1);
      chk("hold_busy", busy, 0);
    end
  endtask

  initial begin
    rst = 0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_res", result, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_err", err, 0);
    rst = 1;
    step();

    run_op(2'b00, 9, 7, 0, 10);
    run_op(2'b01, 3, 5, 0, 1);
    run_op(2'b01, 5, 3, 0, 1);
    run_op(2'b10, 15, 15, 1, 2);
    run_op(2'b11, 13, 4, 0, 1);
    run_op(2'b11, 0, 7, 0, 0);
    run_op(2'b11, 15, 1, 0, 0);
    run_op(2'b11, 9, 0, 0, 1);
    run_op(2'b00, 15, 15, 0, 0);
    run_op(2'b10, 0, 9, 0, 0);

    // Reset in the middle of a multiply discards it.
    go = 1; op = 2'b10; a = 6; b = 7;
    step();
    go = 0;
    step();
    rst = 0;
    step();
    chk("midrst_busy", busy, 0);
    chk("midrst_res", result, 0);
    chk("midrst_rv", result_valid, 0);
    rst = 1;
    last_res = '0;
    run_op(2'b10, 6, 7, 0, 1);

    // Reset beats go on the same edge.
    rst = 0; go = 1; op = 2'b00; a = 1; b = 1;
    step();
    rst = 1; go = 0;
    chk("rstgo_busy", busy, 0);
    chk("rstgo_rv", result_valid, 0);
    step();
    chk("rstgo_idle", busy, 0);
    last_res = '0;

    for (int t = 0; t < 60; t++)
      run_op(2'($urandom), W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/calc_alu_seq.md
Name: calc_alu_seq

Overview:
Sequential arithmetic core directly upstream of the two-digit 7-segment display driver. Accepts two unsigned operands and an opcode on a single-cycle `go` pulse and computes add, subtract, multiply (shift-add) or divide (restoring). It presents an 8-bit result plus a level `result_valid`. `result_valid` drives the display driver's `start` input and `result` drives its `in_data`.

Parameters:
WIDTH, 4, operand width in bits; result width is 2*WIDTH (8 at default, matching the display's two hex digits).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (rst=0 at a rising edge resets the block)
go  input  1  start request; sampled only in IDLE
op  input  2  opcode: 00 add, 01 sub, 10 mul, 11 div
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
busy  output  1  high from accepting edge through final CALC cycle
result  output  2*WIDTH  registered result
result_valid  output  1  result holds a completed value (level)
err  output  1  divide-by-zero flag for the current result

Behaviour:
- Reset (rst=0 at edge): state=IDLE, result=0, result_valid=0, busy=0, err=0, internal counter/accumulators=0. Reset overrides everything, including mid-CALC; partial results are discarded.
- States: IDLE, CALC.
- IDLE, go=1 at an edge:
  - latch a, b, op;
  - busy<=1, result_valid<=0, err<=0;
  - iteration counter <= 0;
  - go to CALC.
- IDLE, go=0: hold all outputs.
- CALC, add/sub, and div with b==0: completes in one cycle. On the next edge: result written, result_valid<=1, busy<=0, go to IDLE.
- CALC, mul/div with b!=0: exactly WIDTH iterations, one per cycle. On the edge ending iteration WIDTH: result written, result_valid<=1, busy<=0, go to IDLE.
- Latency, counted from the edge accepting go to the edge asserting result_valid:
  - add/sub/div-by-zero: 2 edges;
  - mul/div: 1+WIDTH edges (5 at default).
- go while busy (CALC) is ignored entirely: no restart, no queueing. Latched operands are unaffected by later changes to a/b/op.
- result/result_valid/err hold until the next accepted go. That edge clears result_valid and err, but result keeps its old value until overwritten.
- Arithmetic, result is 2*WIDTH bits:
  - add: zero-extended a+b; max 2*(2^WIDTH-1), no overflow.
  - sub: a-b computed in 2*WIDTH bits, two's complement, so negative values wrap, e.g. 3-5=8'hFE.
  - mul: unsigned shift-add, LSB of multiplier first, product exact.
  - div: restoring, MSB first. Quotient in result[2*WIDTH-1:WIDTH], remainder in result[WIDTH-1:0].
  - div with b==0: result=all ones, err=1.
- err is asserted only for div-by-zero, on the same edge as result_valid.
- go asserted on the same edge that CALC finishes: not accepted, because the state is not yet IDLE. go must be presented in IDLE.
- go asserted on the same edge as rst=0: reset wins; the block stays IDLE with result_valid=0.

Test Plan:
1. Reset, then go with op=00, a=9, b=7 → busy=1 for 1 cycle; after 2 edges result=8'h10, result_valid=1, err=0; values held with go=0 for 10 cycles.
2. op=01, a=3, b=5 → result=8'hFE after 2 edges. Then op=01, a=5, b=3 → result_valid drops on the accepting edge, next result=8'h02.
3. op=10, a=15, b=15 → busy high 5 edges, result=8'hE1, result_valid at edge 5. Pulse go again at edge 2 with a=1, b=1 → ignored, result still 8'hE1.
4. op=11, a=13, b=4 → after 5 edges result=8'h31 (q=3, r=1), err=0. Also a=0, b=7 → 8'h00; a=15, b=1 → 8'hF0.
5. op=11, a=9, b=0 → after 2 edges result=8'hFF, err=1. Next accepted go clears err on its accepting edge.
6. Start op=10, a=6, b=7; drive rst=0 at edge 3 → busy=0, result=0, result_valid=0 next cycle. Re-run the same op after reset → result=8'h2A.
